exe_stage: RTL

//  Execute stage of the 5-stage MIPS pipeline. Consumes ds_to_es_bus from decode and drives es_to_ms_bus to memory stage.

---
 rtl/exe_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ALU, HI/LO pair, single-cycle multiplier,
// 32-step restoring divider, data-SRAM request and forwarding info back to decode.
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 145,
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int ES_FWD_BUS_WD   = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    typedef struct packed {
        logic        mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
        logic [11:0] alu_op;
        logic        load_op, src1_is_sa, src1_is_pc, src2_is_imm;
        logic        src2_is_uimm, src2_is_8, gr_we, mem_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_value, rt_value, pc;
    } ds_bus_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    ds_bus_t     ds;
    logic        es_valid;
    logic        es_ready_go;
    logic        es_retire;
    logic        es_is_div;
    logic [31:0] src1, src2;
    logic [31:0] add_result, sub_result, alu_result, es_result;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] hi, lo;

    div_state_t  div_state, div_next;
    logic        div_start, div_step;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem, div_quot, div_dsor;
    logic        div_q_neg, div_r_neg;
    logic [32:0] div_trial;
    logic [31:0] dividend_abs, divisor_abs;
    logic [31:0] quot_fixed, rem_fixed;

    // ---------------- pipeline handshake ----------------
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_retire      = es_valid && es_ready_go && ms_allowin;
    assign es_is_div      = ds.div | ds.divu;

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                             ds <= '0;
        else if (es_allowin && ds_to_es_valid)   ds <= ds_to_es_bus;
    end

    // ---------------- operands and ALU ----------------
    assign src1 = ds.src1_is_sa   ? {27'b0, ds.imm[10:6]} :
                  ds.src1_is_pc   ? ds.pc : ds.rs_value;
    assign src2 = ds.src2_is_imm  ? {{16{ds.imm[15]}}, ds.imm} :
                  ds.src2_is_uimm ? {16'b0, ds.imm} :
                  ds.src2_is_8    ? 32'd8 : ds.rt_value;

    assign add_result = src1 + src2;
    assign sub_result = src1 - src2;

    always_comb begin
        // NOTE: default first so every path assigns alu_result and no latch is inferred.
        alu_result = '0;
        if (ds.alu_op[0])  alu_result = alu_result | add_result;
        if (ds.alu_op[1])  alu_result = alu_result | sub_result;
        if (ds.alu_op[2])  alu_result = alu_result | {31'b0, $signed(src1) < $signed(src2)};
        if (ds.alu_op[3])  alu_result = alu_result | {31'b0, src1 < src2};
        if (ds.alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (ds.alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (ds.alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (ds.alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (ds.alu_op[8])  alu_result = alu_result | (src2 << src1[4:0]);
        if (ds.alu_op[9])  alu_result = alu_result | (src2 >> src1[4:0]);
        if (ds.alu_op[10]) alu_result = alu_result | 32'($signed(src2) >>> src1[4:0]);
        if (ds.alu_op[11]) alu_result = alu_result | {src2[15:0], 16'b0};
    end

    assign es_result = ds.mfhi ? hi : ds.mflo ? lo : alu_result;

    // Sign-extending to 64 bits lets one unsigned multiplier serve both mult and multu.
    assign mul_a   = {{32{ds.mult & ds.rs_value[31]}}, ds.rs_value};
    assign mul_b   = {{32{ds.mult & ds.rt_value[31]}}, ds.rt_value};
    assign product = mul_a * mul_b;

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) div_state <= DIV_IDLE;
        else         div_state <= div_next;
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            DIV_IDLE: if (div_start)        div_next = DIV_BUSY;
            DIV_BUSY: if (div_cnt == 5'd31) div_next = DIV_DONE;
            DIV_DONE: if (es_retire)        div_next = DIV_IDLE;
            default:                        div_next = DIV_IDLE;
        endcase
    end

    always_comb begin
        div_start   = (div_state == DIV_IDLE) && es_valid && es_is_div;
        div_step    = (div_state == DIV_BUSY);
        es_ready_go = !(es_is_div && (div_state != DIV_DONE));
    end

    assign dividend_abs = (ds.div && ds.rs_value[31]) ? -ds.rs_value : ds.rs_value;
    assign divisor_abs  = (ds.div && ds.rt_value[31]) ? -ds.rt_value : ds.rt_value;
    assign div_trial    = {div_rem, div_quot[31]} - {1'b0, div_dsor};

    // NOTE: the divider datapath is reset alongside HI/LO so an aborted divide leaves nothing behind.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quot  <= '0;
            div_dsor  <= '0;
            div_q_neg <= 1'b0;
            div_r_neg <= 1'b0;
        end else if (div_start) begin
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quot  <= dividend_abs;
            div_dsor  <= divisor_abs;
            div_q_neg <= ds.div & (ds.rs_value[31] ^ ds.rt_value[31]);
            div_r_neg <= ds.div & ds.rs_value[31];
        end else if (div_step) begin
            div_cnt <= div_cnt + 5'd1;
            // A zero divisor never makes the trial negative: quotient saturates, remainder = dividend.
            if (!div_trial[32]) begin
                div_rem  <= div_trial[31:0];
                div_quot <= {div_quot[30:0], 1'b1};
            end else begin
                div_rem  <= {div_rem[30:0], div_quot[31]};
                div_quot <= {div_quot[30:0], 1'b0};
            end
        end
    end

    assign quot_fixed = div_q_neg ? -div_quot : div_quot;
    assign rem_fixed  = div_r_neg ? -div_rem  : div_rem;

    // ---------------- HI/LO: architectural update only on retire ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (es_retire) begin
            if (ds.mult | ds.multu) {hi, lo} <= product;
            if (es_is_div) begin
                lo <= quot_fixed;
                hi <= rem_fixed;
            end
            if (ds.mthi) hi <= ds.rs_value;
            if (ds.mtlo) lo <= ds.rs_value;
        end
    end

    // ---------------- memory request and outgoing buses ----------------
    assign data_sram_en    = es_valid && (ds.load_op || ds.mem_we);
    assign data_sram_wen   = {4{es_valid && ds.mem_we}};
    assign data_sram_addr  = add_result;
    assign data_sram_wdata = ds.rt_value;

    assign es_to_ms_bus = {ds.load_op, ds.gr_we, ds.dest, es_result, ds.pc};
    assign es_fwd_bus   = {es_valid && ds.load_op, es_valid && ds.gr_we, ds.dest, es_result};

endmodule
